// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB4 register-memory completer.
package apb_slave_mem_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int MEM_DEPTH   = 256;
  localparam int WAIT_STATES = 0;
  localparam int ADDR_LSB    = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_WAIT   = 3'b010,
    S_ACCESS = 3'b100
  } slave_state_e;

  // Replaces only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_word,
    input logic [DATA_WIDTH-1:0]   new_word,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word-organised register array with byte-lane write enables, asynchronous
// clear and a single combinational read port.
module apb_slave_regfile #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_we,
  input  logic [AW-1:0]                            i_waddr,
  input  logic [apb_slave_mem_pkg::DATA_WIDTH-1:0] i_wdata,
  input  logic [apb_slave_mem_pkg::DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [AW-1:0]                            i_raddr,
  output logic [apb_slave_mem_pkg::DATA_WIDTH-1:0] o_rdata
);
  import apb_slave_mem_pkg::*;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, strobed byte merge on write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= merge_bytes(r_mem[i_waddr], i_wdata, i_wstrb);
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer: setup-phase capture, fixed wait states, address checking
// and registered PREADY/PSLVERR/PRDATA in front of the register array.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = apb_slave_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = apb_slave_mem_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH   = apb_slave_mem_pkg::MEM_DEPTH,
  parameter int WAIT_STATES = apb_slave_mem_pkg::WAIT_STATES
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  import apb_slave_mem_pkg::*;

  localparam int IDX_W  = ADDR_WIDTH - ADDR_LSB;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  slave_state_e            r_state;
  logic [3:0]              r_wait_cnt;
  logic                    r_write;
  logic                    r_illegal;
  logic [MEM_AW-1:0]       r_widx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_strb;
  logic [DATA_WIDTH-1:0]   r_rdata_lat;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;

  logic [IDX_W-1:0]        w_index;
  logic                    w_illegal;
  logic                    w_setup;
  logic                    w_we;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic [DATA_WIDTH-1:0]   w_rd_val;

  assign w_index   = PADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_illegal = (PADDR[ADDR_LSB-1:0] != 2'b00) || (w_index >= IDX_W'(MEM_DEPTH));
  assign w_setup   = PSEL && !PENABLE;
  assign w_rd_val  = (!PWRITE && !w_illegal) ? w_rdata : {DATA_WIDTH{1'b0}};
  // Commit uses only the captured fields; a PSEL drop in the access cycle cancels it.
  assign w_we      = (r_state == S_ACCESS) && PSEL && r_write && !r_illegal;

  apb_slave_regfile #(
    .DEPTH (MEM_DEPTH),
    .AW    (MEM_AW)
  ) u_regfile (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_we    (w_we),
    .i_waddr (r_widx),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_raddr (w_index[MEM_AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Transfer FSM, wait counter, captured fields and registered responses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_write     <= 1'b0;
      r_illegal   <= 1'b0;
      r_widx      <= {MEM_AW{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_strb      <= {STRB_W{1'b0}};
      r_rdata_lat <= {DATA_WIDTH{1'b0}};
      r_prdata    <= {DATA_WIDTH{1'b0}};
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_write     <= PWRITE;
            r_illegal   <= w_illegal;
            r_widx      <= w_index[MEM_AW-1:0];
            r_wdata     <= PWDATA;
            r_strb      <= PSTRB;
            r_rdata_lat <= w_rd_val;
            if (WAIT_STATES > 0) begin
              r_wait_cnt <= WAIT_LOAD;
              r_state    <= S_WAIT;
              r_pready   <= 1'b0;
              r_pslverr  <= 1'b0;
              r_prdata   <= {DATA_WIDTH{1'b0}};
            end else begin
              r_state    <= S_ACCESS;
              r_pready   <= 1'b1;
              r_pslverr  <= w_illegal;
              r_prdata   <= w_rd_val;
            end
          end else begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DATA_WIDTH{1'b0}};
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DATA_WIDTH{1'b0}};
          end else if (r_wait_cnt == 4'd0) begin
            r_state   <= S_ACCESS;
            r_pready  <= 1'b1;
            r_pslverr <= r_illegal;
            r_prdata  <= r_rdata_lat;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= {DATA_WIDTH{1'b0}};
        end
        default: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= 4'd0;
          r_pready   <= 1'b0;
          r_pslverr  <= 1'b0;
          r_prdata   <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;
  assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed and scoreboard checks for apb_slave_mem with 0 and 3 wait states.
module tb_apb_slave_mem;

  localparam int CONST_LOOP = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; returns at the negedge where PREADY is seen high.
  task automatic xfer(input bit sel3, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int cyc);
    @(negedge clk);
    psel0 = !sel3; psel3 = sel3; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~wdata;
    cyc = 2;
    while (!(sel3 ? pready3 : pready0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rdata = sel3 ? prdata3 : prdata0;
    err   = sel3 ? pslverr3 : pslverr0;
    if (!(sel3 ? pready3 : pready0)) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got PREADY=0 after %0d cycles expected PREADY=1", cyc);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, m, d;
    logic        er, w;
    logic [3:0]  s;
    int          cyc, k;
    logic [31:0] model [16];

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h14,  32'h12345678, 4'h3, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h14,  32'h0,        4'hF, 32'hFFFF5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h11,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h18,  32'h11111111, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h18,  32'h0,        4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h0,   32'h00000001, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h00000001, 1'b0};
    vecs[13] = '{1'b1, 32'h14,  32'hAABBCCDD, 4'hC, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h14,  32'h0,        4'h0, 32'hAABB5678, 1'b0};

    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_pready", {31'h0, pready0}, 32'h0);
    check("reset_pslverr", {31'h0, pslverr0}, 32'h0);
    check("reset_prdata", prdata0, 32'h0);
    rst = 1'b0;

    // Table vectors, issued back to back on the zero-wait instance.
    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, cyc);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_cycles", i), cyc, 32'd2);
    end
    idle();
    check("idle_pready", {31'h0, pready0}, 32'h0);

    // Three wait states: write, then read with the access phase watched cycle by cycle.
    xfer(1'b1, 1'b1, 32'h0, 32'h5A5A0000, 4'hF, rd, er, cyc);
    check("ws3_write_cycles", cyc, 32'd5);
    @(negedge clk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(negedge clk);
    penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ws3_wait%0d_pready", c), {31'h0, pready3}, 32'h0);
      check($sformatf("ws3_wait%0d_prdata", c), prdata3, 32'h0);
      @(negedge clk);
    end
    check("ws3_ready", {31'h0, pready3}, 32'h1);
    check("ws3_rdata", prdata3, 32'h5A5A0000);
    check("ws3_err", {31'h0, pslverr3}, 32'h0);
    xfer(1'b1, 1'b0, 32'h11, 32'h0, 4'h0, rd, er, cyc);
    check("ws3_misaligned_err", {31'h0, er}, 32'h1);
    check("ws3_misaligned_cycles", cyc, 32'd5);

    // Abort during wait: PSEL drops, the write must not land.
    @(negedge clk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel3 = 1'b0; penable = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pready", {31'h0, pready3}, 32'h0);
    xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
    check("abort_rdata", rd, 32'h0);

    // Reset while dut0 holds PREADY high: response clears without a clock edge.
    @(negedge clk);
    psel0 = 1'b1; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h7;
    @(negedge clk);
    penable = 1'b1;
    check("pre_rst_pready", {31'h0, pready0}, 32'h1);
    #1 rst = 1'b1;
    #1 check("async_rst_pready0", {31'h0, pready0}, 32'h0);
    @(negedge clk);
    rst = 1'b0; psel0 = 1'b0; penable = 1'b0;

    // Reset in S_WAIT of a write to 0x20 on the wait-state instance.
    @(negedge clk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h1; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_wait_pready3", {31'h0, pready3}, 32'h0);
    @(negedge clk);
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    check("rst_wait_rdata", rd, 32'h0);
    xfer(1'b0, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, cyc);
    check("rst_access_rdata", rd, 32'h0);

    // Soak against a scoreboard on the zero-wait instance.
    reset_pulse();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    for (int i = 0; i < CONST_LOOP; i++) begin
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 17);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (k == 16) m = 32'h400 + 32'(4 * $urandom_range(0, 15));
      else if (k == 17) m = 32'h5;
      else m = 32'(4 * k);
      xfer(1'b0, w, m, d, s, rd, er, cyc);
      check($sformatf("soak%0d_err", i), {31'h0, er}, {31'h0, (k >= 16)});
      if (w || k >= 16) begin
        check($sformatf("soak%0d_rdata", i), rd, 32'h0);
      end else begin
        check($sformatf("soak%0d_rdata", i), rd, model[k]);
      end
      if (w && k < 16) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
        end
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB4 completer (slave) with a word-addressed register memory. It answers the APB initiator that drives `IDLE`/`SETUP`/`ACCESS` transfers on the same bus. It serves reads and byte-strobed writes, inserts a fixed number of wait states, and flags illegal addresses with PSLVERR. It sits at slave index 0 of the APB fabric and is the DUT-side counterpart that the initiator agent and its multi-test suite exercise.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32.
- ADDR_WIDTH, 32, PADDR width.
- MEM_DEPTH, 256, number of 32-bit words.
- WAIT_STATES, 0, extra access-phase cycles before PREADY; range 0..15.
- PCLK  in  1  single clock; all state changes on the rising edge.
- PRESET  in  1  reset; asynchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables.
- PRDATA  out  DATA_WIDTH  read data; valid while PREADY=1 on a read.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- Word index is PADDR[ADDR_WIDTH-1:2].
- An address is illegal if PADDR[1:0] != 0 or the word index is >= MEM_DEPTH.
- FSM uses one-hot encoding: S_IDLE=3'b001, S_WAIT=3'b010, S_ACCESS=3'b100.
- S_IDLE, with PSEL=1 and PENABLE=0 (setup phase):
  - Latch PWRITE, PADDR, PWDATA and PSTRB.
  - Latch the illegal flag.
  - Load PRDATA with mem[index] for a legal read, else 0.
  - Load the wait counter with WAIT_STATES-1.
  - Next state is S_WAIT if WAIT_STATES>0, else S_ACCESS.
- S_WAIT: if the counter is 0, go to S_ACCESS; else decrement the counter.
- S_ACCESS: PREADY=1 and PSLVERR = latched illegal flag. Next state is S_IDLE.
- Write commit happens at the S_ACCESS edge only, and only if the transfer is legal. Each byte lane i with PSTRB[i]=1 is updated; the other lanes keep their value.
- Reads ignore PSTRB. A write with PSTRB=0 is legal and changes nothing.
- Abort: PSEL=0 in S_WAIT or S_ACCESS sends the FSM to S_IDLE. PREADY goes to 0 and no write occurs.
- PENABLE=1 while in S_IDLE (protocol violation) is ignored; the FSM stays in S_IDLE.
- Latched fields are used for the whole transfer. Changes on PADDR/PWDATA during the access phase have no effect.
- Reset state:
  - FSM in S_IDLE, counter 0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All memory words 0.
- Reset mid-transfer discards the pending write.
- PREADY, PSLVERR and PRDATA are registered decodes: no combinational path from the bus inputs.

## Timing
- Setup cycle is 1 cycle; the access phase lasts WAIT_STATES+1 cycles. Total transfer is WAIT_STATES+2 cycles.
- With WAIT_STATES=0, PREADY is high in the first PENABLE cycle.
- Back-to-back: the cycle after PREADY the FSM is in S_IDLE, so a new setup phase is accepted immediately with zero idle cycles.
- A read issued right after a write to the same address returns the new data (the write commits before the next setup-phase sample).
- PSLVERR=0 and PRDATA hold 0 whenever PREADY=0. PRDATA is 0 on a write transfer's PREADY cycle.

## Structure
- Add the following to shared_pkg:
  - slave_state_e (S_IDLE/S_WAIT/S_ACCESS, one-hot, logic [2:0]).
  - MEM_DEPTH = 256.
  - WAIT_STATES = 0.
  - ADDR_LSB = 2.
- Reuse DATA_WIDTH and ADDR_WIDTH from the package.
- One sub-module, apb_slave_regfile:
  - MEM_DEPTH x 32 array with per-byte write enables.
  - Asynchronous clear on PRESET.
  - One combinational read port.
- The top level holds the FSM, the wait counter, the address check and the output registers.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10. Required: PREADY in the first access cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0xFFFFFFFF, then write 0x12345678 with PSTRB=4'b0011, then read. Required: PRDATA=0xFFFF5678.
- Errors, with MEM_DEPTH=256:
  - Write 0xA5A5A5A5 to 0x400: PSLVERR=1 with PREADY.
  - Read 0x3FC: returns the prior value, PSLVERR=0.
  - Read 0x11: PSLVERR=1, PRDATA=0.
- WAIT_STATES=3: read 0x0. Required: PREADY low for 3 access cycles, high on the 4th; 5 cycles total.
- Reset mid-transfer: assert PRESET in S_WAIT during a write of 0x1 to 0x20. Required: PREADY=0 immediately (asynchronous), and a subsequent read of 0x20 returns 0.
- Back-to-back: write 0x1 to 0x0, then immediately read 0x0 with no idle cycle. Required: PRDATA=0x1. Also run a CONST_LOOP random read/write soak against a scoreboard model.
